// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg
// Shared definitions for the E-stage multiply/divide unit: the md_op encodings
// driven by the decoder, the default MULT/DIV latencies, the unit's FSM state
// type and a helper that tells whether an op launches a multi-cycle operation.
// -----------------------------------------------------------------------------
package md_unit_pkg;

    // Operation codes as carried on the 4-bit md_op bus
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // Default number of busy cycles for each operation class
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // IDLE waits for a launch, RUN counts the operation down to its commit
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for the four ops that occupy the unit for several cycles
    function automatic logic isLongOp(input md_op_e op);
        logic result;
        result = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: result = 1'b1;
            default:                            result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Multiply/divide unit living in the E stage. Holds the architectural HI/LO
// pair, computes MULT/MULTU/DIV/DIVU results in the launch cycle into temp
// registers, and then keeps itself busy for a fixed latency before committing
// them to HI/LO. MTHI/MTLO write HI/LO directly; MFHI/MFLO are served through
// XALUOUT.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous, active-high reset
//   A         in  32   rs operand (forwarded)
//   B         in  32   rt operand (forwarded)
//   md_op     in   4   operation code (md_op_e)
//   start     in   1   one-cycle pulse for a MULT/MULTU/DIV/DIVU in E
//   int_req   in   1   exception being taken; blocks launches and MTHI/MTLO
//   busy      out  1   operation in flight
//   md_stall  out  1   busy | start, to the hazard unit
//   XALUOUT   out 32   HI for MFHI, LO for MFLO, otherwise 0
// -----------------------------------------------------------------------------
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic        int_req,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] XALUOUT
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_op_e           op;
    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      tmp_hi_q, tmp_hi_d;
    logic [31:0]      tmp_lo_q, tmp_lo_d;
    logic             wr_q, wr_d;

    logic [63:0]      a_sx, b_sx, a_zx, b_zx;
    logic [63:0]      b_div_sx, b_div_zx;
    logic [63:0]      prod_s, prod_u;
    logic             b_zero;
    logic [31:0]      res_hi, res_lo;
    logic             launch;

    assign op = md_op_e'(md_op);

    // Operand extension and the raw arithmetic. The divisor is forced to 1
    // when B is zero so the divider never sees a zero; that result is thrown
    // away because a divide by zero leaves HI/LO untouched.
    assign a_sx     = {{32{A[31]}}, A};
    assign b_sx     = {{32{B[31]}}, B};
    assign a_zx     = {32'd0, A};
    assign b_zx     = {32'd0, B};
    assign b_zero   = (B == 32'd0);
    assign b_div_sx = b_zero ? 64'd1 : b_sx;
    assign b_div_zx = b_zero ? 64'd1 : b_zx;
    assign prod_s   = $signed(a_sx) * $signed(b_sx);
    assign prod_u   = a_zx * b_zx;

    // Pick the HI/LO pair for whichever long op is presented this cycle.
    // Doing the signed divide at 64 bits makes 0x80000000 / -1 come out as
    // LO=0x80000000, HI=0 without any special case.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_lo = 32'($signed(a_sx) / $signed(b_div_sx));
                res_hi = 32'($signed(a_sx) % $signed(b_div_sx));
            end
            MD_DIVU: begin
                res_lo = 32'(a_zx / b_div_zx);
                res_hi = 32'(a_zx % b_div_zx);
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    // A launch needs an idle unit, a real long op and no exception this cycle
    assign launch = start && isLongOp(op) && !int_req && (state_q == ST_IDLE);

    // Next-state logic: IDLE either launches or services MTHI/MTLO; RUN counts
    // down and commits the temps on the edge after the counter reaches 1.
    // int_req is deliberately ignored in RUN since that instruction has
    // already retired past E.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        wr_d     = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d  = ST_RUN;
                    tmp_hi_d = res_hi;
                    tmp_lo_d = res_lo;
                    wr_d     = !(((op == MD_DIV) || (op == MD_DIVU)) && b_zero);
                    if ((op == MD_MULT) || (op == MD_MULTU)) begin
                        cnt_d = CNT_W'(MULT_LAT);
                    end else begin
                        cnt_d = CNT_W'(DIV_LAT);
                    end
                end else if (!int_req) begin
                    if (op == MD_MTHI) begin
                        hi_d = A;
                    end
                    if (op == MD_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (wr_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers; reset wins over anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            wr_q     <= wr_d;
        end
    end

    // Outputs: the stall covers the launch cycle and every busy cycle
    // including the commit one, and reads always see the current HI/LO.
    assign busy     = (state_q == ST_RUN);
    assign md_stall = start | busy;

    always_comb begin
        XALUOUT = 32'd0;
        if (op == MD_MFHI) begin
            XALUOUT = hi_q;
        end else if (op == MD_MFLO) begin
            XALUOUT = lo_q;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit
// Directed-vector bench for md_unit with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  md_op;
    logic        start;
    logic        int_req;
    logic        busy;
    logic        md_stall;
    logic [31:0] XALUOUT;

    int checks;
    int errors;

    md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .md_op    (md_op),
        .start    (start),
        .int_req  (int_req),
        .busy     (busy),
        .md_stall (md_stall),
        .XALUOUT  (XALUOUT)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs
    task automatic applyStimulus(input md_op_e op, input logic [31:0] a,
                                 input logic [31:0] b, input logic st,
                                 input logic irq);
        md_op   = op;
        A       = a;
        B       = b;
        start   = st;
        int_req = irq;
    endtask

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read HI and LO through XALUOUT
    task automatic checkHiLo(input string tag, input logic [31:0] expHi,
                             input logic [31:0] expLo);
        md_op = MD_MFHI;
        #1;
        checkOutput({tag, " HI"}, XALUOUT, expHi);
        md_op = MD_MFLO;
        #1;
        checkOutput({tag, " LO"}, XALUOUT, expLo);
        md_op = MD_NONE;
    endtask

    // Launch a long op, check the stall, the pre-commit HI, the busy length
    // and the committed HI/LO
    task automatic runOp(input string tag, input md_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input int expLat,
                         input logic [31:0] preHi, input logic [31:0] expHi,
                         input logic [31:0] expLo);
        int n;
        applyStimulus(op, a, b, 1'b1, 1'b0);
        #1;
        checkOutput({tag, " stall on start"}, 32'(md_stall), 32'd1);
        tick();
        applyStimulus(MD_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        checkOutput({tag, " pre-commit HI"}, XALUOUT, preHi);
        checkOutput({tag, " stall while busy"}, 32'(md_stall), 32'd1);
        md_op = MD_NONE;
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
        checkOutput({tag, " busy cycles"}, 32'(n), 32'(expLat));
        checkHiLo(tag, expHi, expLo);
    endtask

    // Safety net against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset for two cycles
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset stall", 32'(md_stall), 32'd0);
        checkHiLo("reset", 32'd0, 32'd0);

        // Multiplies
        runOp("MULT -2*3", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5,
              32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runOp("MULTU", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5,
              32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFA);

        // Divides
        runOp("DIV -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10,
              32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("DIVU 7/2", MD_DIVU, 32'd7, 32'd2, 10,
              32'hFFFF_FFFF, 32'd1, 32'd3);
        runOp("DIV min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
              32'd1, 32'd0, 32'h8000_0000);

        // MTHI/MTLO then divide by zero
        applyStimulus(MD_MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(MD_MTLO, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        checkHiLo("MTHI/MTLO", 32'h0000_1234, 32'h0000_5678);
        runOp("DIV by 0", MD_DIV, 32'd99, 32'd0, 10,
              32'h0000_1234, 32'h0000_1234, 32'h0000_5678);

        // Launch blocked by int_req
        applyStimulus(MD_MULT, 32'd3, 32'd4, 1'b1, 1'b1);
        tick();
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("int_req start busy", 32'(busy), 32'd0);
        checkHiLo("int_req start", 32'h0000_1234, 32'h0000_5678);
        applyStimulus(MD_MTLO, 32'h0000_DEAD, 32'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        checkHiLo("int_req MTLO", 32'h0000_1234, 32'h0000_5678);

        // Second start on the third busy cycle of a MULT is ignored
        applyStimulus(MD_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
        tick();
        n = 0;
        while (busy && n < 50) begin
            n++;
            if (n == 3) applyStimulus(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
            else        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("restart ignored busy cycles", 32'(n), 32'd5);
        checkHiLo("restart ignored", 32'd0, 32'd12);

        // Reset in cycle 2 of a DIV kills it
        applyStimulus(MD_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
        tick();
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("DIV cycle2 busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid-DIV reset busy", 32'(busy), 32'd0);
        checkHiLo("mid-DIV reset", 32'd0, 32'd0);
        repeat (12) tick();
        checkOutput("no late commit busy", 32'(busy), 32'd0);
        checkHiLo("no late commit", 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
